mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port M10K data-memory port (e.g. `fpga_mem_c`) between several matrix engines: the element-wise FSM, the MatMul engine and a future transpose engine. It sits between the engines' `mem_t`-style request buses and the unpacked memory pins. It forwards one granted access per cycle and supports locked bursts, so an engine can hold the port for a whole block write. It routes read data back to the requester that issued the read, using a fixed-latency owner tag pipeline.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_rr_picker.sv | 34 +++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, default
// requester count and the byte-enable level driven on every access.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int MEM_ARB_NUM_REQ = 2;

  // Every byte lane is always enabled; replicated to DATA_BITS/8 in the top.
  localparam logic MEM_ARB_BYTEEN_ON = 1'b1;

  // Successor of a requester index in the round-robin order.
  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1) % modulus;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational rotating-priority picker: returns the first requester with
// req=1, searching upward from ptr with wrap. ptr tied to 0 gives fixed
// priority (lowest index wins).
module rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = MEM_ARB_NUM_REQ,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [PTR_W-1:0]   win_idx,
  output logic               found
);

  // Scan the requesters in priority order starting at ptr.
  always_comb begin : p_search
    int idx;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between NUM_REQ engines. One access per
// cycle, combinational grant, locked bursts, and a one-hot owner tag
// pipeline that routes read data back to the issuing requester.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no rotating pointer); otherwise round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = MEM_ARB_NUM_REQ,
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_BITS    = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0]                  lock,
  input  logic [NUM_REQ-1:0]                  rd,
  input  logic [NUM_REQ-1:0]                  wr,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_REQ-1:0][DATA_BITS-1:0]   wdata,
  output logic [NUM_REQ-1:0]                  gnt,
  output logic [NUM_REQ-1:0]                  rvalid,
  output logic [DATA_BITS-1:0]                rdata,
  output logic [ADDR_WIDTH-1:0]               mem_address,
  output logic                                mem_chipselect,
  output logic                                mem_write,
  output logic [DATA_BITS-1:0]                mem_writedata,
  output logic                                mem_clken,
  output logic [DATA_BITS/8-1:0]              mem_byteenable,
  input  logic [DATA_BITS-1:0]                mem_readdata
);

  localparam int PTR_W      = $clog2(NUM_REQ);
  // One stage per cycle of memory latency plus the rdata register.
  localparam int PIPE_DEPTH = READ_LATENCY + 1;

  arb_state_t                         state, state_next;
  logic [PTR_W-1:0]                   owner, owner_next;
  logic [PTR_W-1:0]                   ptr_in;
  logic [NUM_REQ-1:0]                 pick_win;
  logic [PTR_W-1:0]                   pick_idx;
  logic                               pick_found;
  logic [NUM_REQ-1:0]                 gnt_int;
  logic [PTR_W-1:0]                   grant_idx;
  logic                               grant_any;
  logic [NUM_REQ-1:0]                 tag_in;
  logic [PIPE_DEPTH-1:0][NUM_REQ-1:0] tag_pipe;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req     (req),
    .ptr     (ptr_in),
    .win     (pick_win),
    .win_idx (pick_idx),
    .found   (pick_found)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign ptr_in = '0;
`else
  logic [PTR_W-1:0] rr_ptr;

  // Rotate priority past whoever was served this cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= PTR_W'(wrap_inc(int'(grant_idx), NUM_REQ));
    end
  end

  assign ptr_in = rr_ptr;
`endif

  // Arbitration state and burst owner.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      owner <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  // Grant selection and lock tracking; nothing is granted while in reset.
  always_comb begin
    state_next = state;
    owner_next = owner;
    gnt_int    = '0;
    grant_idx  = '0;
    grant_any  = 1'b0;
    if (reset_n) begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            gnt_int   = pick_win;
            grant_idx = pick_idx;
            grant_any = 1'b1;
            if (lock[pick_idx]) begin
              state_next = ARB_LOCKED;
              owner_next = pick_idx;
            end
          end
        end
        ARB_LOCKED: begin
          // Owner-only; a cycle without req is idle but keeps the lock.
          if (req[owner]) begin
            gnt_int[owner] = 1'b1;
            grant_idx      = owner;
            grant_any      = 1'b1;
          end
          if (!lock[owner]) begin
            state_next = ARB_IDLE;
          end
        end
        default: state_next = ARB_IDLE;
      endcase
    end
  end

  assign gnt            = gnt_int;
  assign mem_chipselect = grant_any & (rd[grant_idx] | wr[grant_idx]);
  assign mem_write      = grant_any & wr[grant_idx];
  assign mem_address    = grant_any ? addr[grant_idx] : '0;
  assign mem_writedata  = grant_any ? wdata[grant_idx] : '0;
  assign mem_clken      = 1'b1;
  assign mem_byteenable = {(DATA_BITS/8){MEM_ARB_BYTEEN_ON}};

  // A read-and-write request is treated as a write, so it carries no tag.
  assign tag_in = (grant_any && rd[grant_idx] && !wr[grant_idx]) ? gnt_int : '0;

  // Owner tags ride alongside the read so rvalid lines up with rdata.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_pipe <= '0;
      rdata    <= '0;
    end else begin
      tag_pipe <= {tag_pipe[PIPE_DEPTH-2:0], tag_in};
      rdata    <= mem_readdata;
    end
  end

  assign rvalid = tag_pipe[PIPE_DEPTH-1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, mid-burst reset
// sequence and randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 11;
  localparam int DW = 256;
  localparam int RL = 1;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b1;
  logic [N-1:0]           req, lock, rd, wr;
  logic [N-1:0][AW-1:0]   addr;
  logic [N-1:0][DW-1:0]   wdata;
  logic [N-1:0]           gnt, rvalid;
  logic [DW-1:0]          rdata;
  logic [AW-1:0]          mem_address;
  logic                   mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0]          mem_writedata;
  logic [DW/8-1:0]        mem_byteenable;
  logic [DW-1:0]          mem_readdata = '0;

  logic [DW-1:0] mem     [0:2047];
  logic [DW-1:0] ref_mem [0:2047];

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int  cyc      = 0;
  int  m_ptr    = 0;
  int  m_owner  = 0;
  bit  m_locked = 1'b0;
  typedef struct {
    int            due;
    int            who;
    logic [DW-1:0] data;
  } rd_t;
  rd_t rq[$];

  typedef struct {
    bit         rst;
    logic [1:0] rq_v, lk_v, rd_v, wr_v;
    int         a0, a1;
    logic [1:0] e_gnt, e_rv;
    logic       e_cs, e_we;
    int         e_addr;
  } vec_t;
  vec_t tbl[$];

  mem_port_arbiter #(
    .NUM_REQ      (N),
    .ADDR_WIDTH   (AW),
    .DATA_BITS    (DW),
    .READ_LATENCY (RL)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req            (req),
    .lock           (lock),
    .rd             (rd),
    .wr             (wr),
    .addr           (addr),
    .wdata          (wdata),
    .gnt            (gnt),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata)
  );

  always #5 clock = ~clock;

  // Single-port memory with one cycle of read latency
  always @(posedge clock) begin
    if (mem_chipselect) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      else           mem_readdata <= mem[mem_address];
    end
  end

  function automatic logic [DW-1:0] init_word(input int a);
    return {8{32'h5A00_0000 | 32'(a)}};
  endfunction

  function automatic logic [DW-1:0] wr_word(input int a, input int who);
    return {8{32'hC0DE_0000 ^ 32'((who << 12) | a)}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void add(input bit rst, input logic [1:0] r, l, rv, wv,
                              input int a0, a1, input logic [1:0] eg, erv,
                              input logic ecs, ewe, input int ea);
    vec_t v;
    v.rst = rst; v.rq_v = r; v.lk_v = l; v.rd_v = rv; v.wr_v = wv;
    v.a0 = a0; v.a1 = a1; v.e_gnt = eg; v.e_rv = erv;
    v.e_cs = ecs; v.e_we = ewe; v.e_addr = ea;
    tbl.push_back(v);
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input logic [1:0] r, l, rdv, wrv, input int a0, a1,
                      output logic [1:0] o_gnt, o_rv, output logic o_cs, o_we,
                      output logic [AW-1:0] o_addr);
    int            widx;
    int            wa;
    logic [1:0]    eg, erv;
    logic          ecs, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    req = r; lock = l; rd = rdv; wr = wrv;
    addr[0] = AW'(a0); addr[1] = AW'(a1);
    wdata[0] = wr_word(a0, 0); wdata[1] = wr_word(a1, 1);
    #1;
    widx = -1;
    if (m_locked) begin
      if (r[m_owner]) widx = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (widx < 0 && r[i]) widx = i;
      end
    end
    eg = '0; ecs = 1'b0; ewe = 1'b0; ea = '0; ewd = '0; wa = 0;
    if (widx >= 0) begin
      eg[widx] = 1'b1;
      wa  = (widx == 0) ? a0 : a1;
      ecs = rdv[widx] | wrv[widx];
      ewe = wrv[widx];
      ea  = AW'(wa);
      ewd = wr_word(wa, widx);
    end
    chk("gnt", DW'(gnt), DW'(eg));
    chk("mem_chipselect", DW'(mem_chipselect), DW'(ecs));
    chk("mem_write", DW'(mem_write), DW'(ewe));
    chk("mem_address", DW'(mem_address), DW'(ea));
    chk("mem_writedata", mem_writedata, ewd);
    erv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      erv[rq[0].who] = 1'b1;
      chk("rdata", rdata, rq[0].data);
      void'(rq.pop_front());
    end
    chk("rvalid", DW'(rvalid), DW'(erv));
    o_gnt = gnt; o_rv = rvalid; o_cs = mem_chipselect; o_we = mem_write; o_addr = mem_address;
    @(posedge clock);
    if (widx >= 0) begin
      if (wrv[widx]) begin
        ref_mem[wa] = wr_word(wa, widx);
      end else if (rdv[widx]) begin
        rd_t e;
        e.due = cyc + RL + 1; e.who = widx; e.data = ref_mem[wa];
        rq.push_back(e);
      end
      if (!FIXED) m_ptr = (widx + 1) % N;
    end
    if (m_locked) begin
      if (!l[m_owner]) m_locked = 1'b0;
    end else if (widx >= 0 && l[widx]) begin
      m_locked = 1'b1;
      m_owner  = widx;
    end
    cyc++;
    @(negedge clock);
  endtask

  // Asynchronous reset asserted mid-cycle, held two edges; called at negedge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_gnt", DW'(gnt), '0);
    chk("rst_chipselect", DW'(mem_chipselect), '0);
    chk("rst_write", DW'(mem_write), '0);
    chk("rst_rvalid", DW'(rvalid), '0);
    chk("rst_rdata", rdata, '0);
    rq.delete();
    m_locked = 1'b0; m_ptr = 0; m_owner = 0;
    repeat (2) begin
      @(posedge clock); #1;
      chk("rst_hold_rvalid", DW'(rvalid), '0);
      chk("rst_hold_gnt", DW'(gnt), '0);
      cyc++;
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0]    og, orv;
    logic          ocs, owe;
    logic [AW-1:0] oa;
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    req = '0; lock = '0; rd = '0; wr = '0; addr = '0; wdata = '0;

    // Directed vectors
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 5, 0, 2'b01, 2'b00, 1, 0, 5);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b01, 0, 0, 0);
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    add(0, 2'b11, 2'b00, 2'b11, 2'b00, 3, 7, 2'b01, 2'b00, 1, 0, 3);
    add(0, 2'b11, 2'b00, 2'b11, 2'b00, 3, 7, FIXED ? 2'b01 : 2'b10, 2'b00, 1, 0, FIXED ? 3 : 7);
    add(0, 2'b11, 2'b00, 2'b11, 2'b00, 3, 7, 2'b01, 2'b01, 1, 0, 3);
    add(0, 2'b11, 2'b00, 2'b11, 2'b00, 3, 7, FIXED ? 2'b01 : 2'b10, FIXED ? 2'b01 : 2'b10, 1, 0, FIXED ? 3 : 7);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b01, 0, 0, 0);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, FIXED ? 2'b01 : 2'b10, 0, 0, 0);
    // Locked 8-word write burst by requester 1 while requester 0 keeps asking
    add(0, 2'b10, 2'b10, 2'b00, 2'b10, 20, 100, 2'b10, 2'b00, 1, 1, 100);
    for (int k = 1; k < 8; k++) begin
      if (k == 4)  // owner pauses without releasing: nobody is granted
        add(0, 2'b01, 2'b10, 2'b01, 2'b10, 20, 0, 2'b00, 2'b00, 0, 0, 0);
      add(0, 2'b11, (k == 7) ? 2'b00 : 2'b10, 2'b01, 2'b10, 20, 100 + k,
          2'b10, 2'b00, 1, 1, 100 + k);
    end
    add(0, 2'b01, 2'b00, 2'b01, 2'b00, 103, 0, 2'b01, 2'b00, 1, 0, 103);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b01, 0, 0, 0);

    @(negedge clock);
    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        step(tbl[i].rq_v, tbl[i].lk_v, tbl[i].rd_v, tbl[i].wr_v, tbl[i].a0, tbl[i].a1,
             og, orv, ocs, owe, oa);
        chk($sformatf("tbl%0d_gnt", i), DW'(og), DW'(tbl[i].e_gnt));
        chk($sformatf("tbl%0d_rvalid", i), DW'(orv), DW'(tbl[i].e_rv));
        chk($sformatf("tbl%0d_cs", i), DW'(ocs), DW'(tbl[i].e_cs));
        chk($sformatf("tbl%0d_we", i), DW'(owe), DW'(tbl[i].e_we));
        chk($sformatf("tbl%0d_addr", i), DW'(oa), DW'(tbl[i].e_addr));
      end
    end

    // Reset mid-burst with a read in flight; afterwards idle with pointer at 0
    step(2'b01, 2'b01, 2'b01, 2'b00, 9, 0, og, orv, ocs, owe, oa);
    chk("burst_start_gnt", DW'(og), DW'(2'b01));
    do_reset();
    step(2'b11, 2'b00, 2'b11, 2'b00, 11, 12, og, orv, ocs, owe, oa);
    chk("post_rst_gnt0", DW'(og), DW'(2'b01));
    chk("post_rst_rvalid0", DW'(orv), '0);
    step(2'b11, 2'b00, 2'b11, 2'b00, 11, 12, og, orv, ocs, owe, oa);
    chk("post_rst_gnt1", DW'(og), DW'(FIXED ? 2'b01 : 2'b10));
    chk("post_rst_rvalid1", DW'(orv), '0);

    // Randomized traffic; an idle owner keeps lock asserted
    for (int t = 0; t < 3000; t++) begin
      logic [1:0] r, l, rv, wv;
      r  = 2'($urandom);
      rv = 2'($urandom);
      wv = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
      l  = (2'($urandom) & (2'($urandom))) | ~r;
      step(r, l, rv, wv, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           og, orv, ocs, owe, oa);
    end
    // Drain outstanding reads
    repeat (4) step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, og, orv, ocs, owe, oa);
    chk("queue_drained", DW'(rq.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
